// File: rtl/alu.sv
// Registered 8-operation ALU with 1-cycle latency and a valid strobe.
// Optional Zero/Overflow flag outputs are enabled by defining ALU_FLAGS_EN.
module alu #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALU_Sel,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             CarryOut,
`ifdef ALU_FLAGS_EN
   output logic             Zero,
   output logic             Overflow,
`endif
   output logic             out_valid
);

   localparam int MSB = WIDTH - 1;

   // Two's-complement overflow from operand and result sign bits only.
   function automatic logic signed_ovf(input logic is_sub, input logic sa,
                                       input logic sb, input logic sr);
      logic sb_eff;
      sb_eff = is_sub ? ~sb : sb;
      return (sa == sb_eff) && (sr != sa);
   endfunction

   // Stage p0: combinational operation, bit WIDTH carries carry/borrow/shifted-out bit
   logic [WIDTH:0] res_p0;
   logic           ovf_p0;

   always_comb begin
      res_p0 = {1'b0, A} + {1'b0, B};
      ovf_p0 = 1'b0;
      case (ALU_Sel)
         3'b000: begin
            res_p0 = {1'b0, A} + {1'b0, B};
            ovf_p0 = signed_ovf(1'b0, A[MSB], B[MSB], res_p0[MSB]);
         end
         3'b001: begin
            res_p0 = {1'b0, A} - {1'b0, B};
            ovf_p0 = signed_ovf(1'b1, A[MSB], B[MSB], res_p0[MSB]);
         end
         3'b010: res_p0 = {1'b0, A & B};
         3'b011: res_p0 = {1'b0, A | B};
         3'b100: res_p0 = {1'b0, A ^ B};
         3'b101: res_p0 = {1'b0, ~A};
         3'b110: res_p0 = {A, 1'b0};
         3'b111: res_p0 = {A[0], 1'b0, A[MSB:1]};
         default: begin
            res_p0 = {1'b0, A} + {1'b0, B};
            ovf_p0 = signed_ovf(1'b0, A[MSB], B[MSB], res_p0[MSB]);
         end
      endcase
   end

   // Stage p1: result registers, loaded only on accepted input
   logic [WIDTH-1:0] out_p1;
   logic             carry_p1;
   logic             zero_p1;
   logic             ovf_p1;
   logic             vld_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_p1   <= '0;
         carry_p1 <= 1'b0;
         zero_p1  <= 1'b0;
         ovf_p1   <= 1'b0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            out_p1   <= res_p0[MSB:0];
            carry_p1 <= res_p0[WIDTH];
            zero_p1  <= (res_p0[MSB:0] == '0);
            ovf_p1   <= ovf_p0;
         end
      end
   end

   assign ALU_Out   = out_p1;
   assign CarryOut  = carry_p1;
   assign out_valid = vld_p1;

`ifdef ALU_FLAGS_EN
   assign Zero     = zero_p1;
   assign Overflow = ovf_p1;
`else
   logic unused_flags;
   assign unused_flags = zero_p1 ^ ovf_p1;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH=4); flag checks active when ALU_FLAGS_EN is defined.
module tb_alu;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] A;
   logic [3:0] B;
   logic [2:0] ALU_Sel;
   logic [3:0] ALU_Out;
   logic       CarryOut;
   logic       out_valid;
`ifdef ALU_FLAGS_EN
   logic       Zero;
   logic       Overflow;
`endif

   int total = 0;
   int bad   = 0;

   alu #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .A        (A),
      .B        (B),
      .ALU_Sel  (ALU_Sel),
      .ALU_Out  (ALU_Out),
      .CarryOut (CarryOut),
`ifdef ALU_FLAGS_EN
      .Zero     (Zero),
      .Overflow (Overflow),
`endif
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                          XOR_ = 3'b100, NOT_ = 3'b101, SHL = 3'b110, SHR = 3'b111;

   // Drive on the falling edge, then sample 1 time unit after the next rising edge.
   task automatic step(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic [2:0] sel);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      A        = a;
      B        = b;
      ALU_Sel  = sel;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] e_out, input logic e_c,
                        input logic e_v, input logic e_z, input logic e_o);
      logic obs_z, obs_o;
`ifdef ALU_FLAGS_EN
      obs_z = Zero;
      obs_o = Overflow;
`else
      obs_z = e_z;
      obs_o = e_o;
`endif
      total++;
      assert (ALU_Out === e_out && CarryOut === e_c && out_valid === e_v &&
              obs_z === e_z && obs_o === e_o)
      else begin
         bad++;
         $error("FAIL %s: got out=%b c=%b v=%b z=%b o=%b, want out=%b c=%b v=%b z=%b o=%b",
                tag, ALU_Out, CarryOut, out_valid, obs_z, obs_o,
                e_out, e_c, e_v, e_z, e_o);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALU_Sel = '0;

      // Reset wins over in_valid
      step(1, 1, 4'hF, 4'h1, ADD); check("rst0",  4'b0000, 0, 0, 0, 0);
      step(1, 1, 4'hF, 4'h1, ADD); check("rst1",  4'b0000, 0, 0, 0, 0);
      step(0, 0, 4'hF, 4'h1, ADD); check("idle0", 4'b0000, 0, 0, 0, 0);
      step(0, 0, 4'hF, 4'h1, ADD); check("idle1", 4'b0000, 0, 0, 0, 0);

      // Capture then hold with in_valid low and changing inputs
      step(0, 1, 4'b0011, 4'b0001, ADD);  check("add3p1", 4'b0100, 0, 1, 0, 0);
      step(0, 0, 4'b1111, 4'b1111, SUB);  check("hold0",  4'b0100, 0, 0, 0, 0);
      step(0, 0, 4'b0000, 4'b0101, SHL);  check("hold1",  4'b0100, 0, 0, 0, 0);
      step(0, 0, 4'b1001, 4'b0110, NOT_); check("hold2",  4'b0100, 0, 0, 0, 0);

      // Back-to-back stream: arithmetic boundaries
      step(0, 1, 4'b1111, 4'b0001, ADD);  check("addwrap", 4'b0000, 1, 1, 1, 0);
      step(0, 1, 4'b0100, 4'b0010, SUB);  check("sub4m2",  4'b0010, 0, 1, 0, 0);
      step(0, 1, 4'b0010, 4'b0100, SUB);  check("sub2m4",  4'b1110, 1, 1, 0, 0);
      step(0, 1, 4'b0110, 4'b0110, SUB);  check("subeq",   4'b0000, 0, 1, 1, 0);
      step(0, 1, 4'b0000, 4'b0001, SUB);  check("sub0m1",  4'b1111, 1, 1, 0, 0);

      // Logic ops
      step(0, 1, 4'b1010, 4'b1100, AND_); check("and",  4'b1000, 0, 1, 0, 0);
      step(0, 1, 4'b1010, 4'b1100, OR_);  check("or",   4'b1110, 0, 1, 0, 0);
      step(0, 1, 4'b1010, 4'b1100, XOR_); check("xor",  4'b0110, 0, 1, 0, 0);
      step(0, 1, 4'b1010, 4'b1100, NOT_); check("not",  4'b0101, 0, 1, 0, 0);

      // Shifts
      step(0, 1, 4'b1010, 4'b1111, SHL);  check("shl",   4'b0100, 1, 1, 0, 0);
      step(0, 1, 4'b1010, 4'b1111, SHR);  check("shr",   4'b0101, 0, 1, 0, 0);
      step(0, 1, 4'b0001, 4'b1111, SHR);  check("shr1",  4'b0000, 1, 1, 1, 0);

      // Signed overflow cases
      step(0, 1, 4'b0111, 4'b0001, ADD);  check("addovf", 4'b1000, 0, 1, 0, 1);
      step(0, 1, 4'b1000, 4'b0001, SUB);  check("subovf", 4'b0111, 0, 1, 0, 1);
      step(0, 1, 4'b1010, 4'b0101, AND_); check("andz",   4'b0000, 0, 1, 1, 0);
      step(0, 1, 4'b1000, 4'b1000, ADD);  check("addnn",  4'b0000, 1, 1, 1, 1);

      // Flags hold with the result when in_valid drops
      step(0, 0, 4'b0001, 4'b0001, ADD);  check("holdflg", 4'b0000, 1, 0, 1, 1);

      // Mid-stream reset clears everything
      step(1, 1, 4'b0111, 4'b0111, ADD);  check("rstmid", 4'b0000, 0, 0, 0, 0);
      step(0, 1, 4'b0101, 4'b0011, XOR_); check("post",   4'b0110, 0, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
